// File: rtl/instruction_ram_wr.sv
// Instruction RAM with a byte-stream loader.
// A load session packs little-endian bytes into 32-bit words and writes them
// to consecutive addresses starting at load_addr. An independent synchronous
// read port serves the sequencer with read-before-write behaviour.
// Optional feature: define INSTR_WR_CHECKSUM_EN to add an XOR checksum output
// covering every word written in the current session.
module instruction_ram_wr #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              busy,
  output logic              load_done,
  input  logic [ADDR_W-1:0] rd_addr,
`ifdef INSTR_WR_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  // One extra bit so a full-depth session (load_len == 0) fits.
  logic [ADDR_W:0]     words_left_q, words_left_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  // Bytes 0..2 of the word being assembled; byte 3 comes straight off the bus.
  logic [23:0]         word_buf_q, word_buf_d;
  logic                byte_ready_q, byte_ready_d;
  logic                busy_q, busy_d;
  logic                load_done_q, load_done_d;

  logic                accept;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;

  logic [DATA_W-1:0]   mem [Depth];

`ifdef INSTR_WR_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  assign checksum = checksum_q;
`endif

  assign byte_ready = byte_ready_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;

  // Handshake and write strobe; a reset edge never commits a word.
  always_comb begin
    accept  = byte_valid && (state_q == StLoad);
    wr_en   = accept && (byte_cnt_q == 2'd3) && !rst;
    wr_data = DATA_W'({byte_data, word_buf_q});
  end

  // Next-state logic for the loader FSM, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    word_buf_d   = word_buf_q;
`ifdef INSTR_WR_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d    = StLoad;
          wr_ptr_d   = load_addr;
          byte_cnt_d = 2'd0;
          word_buf_d = '0;
          if (load_len == '0) begin
            words_left_d = {1'b1, {ADDR_W{1'b0}}};
          end else begin
            words_left_d = {1'b0, load_len};
          end
`ifdef INSTR_WR_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
          if (byte_cnt_q == 2'd3) begin
            wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
            words_left_d = words_left_q - (ADDR_W + 1)'(1);
            byte_cnt_d   = 2'd0;
`ifdef INSTR_WR_CHECKSUM_EN
            checksum_d   = checksum_q ^ wr_data;
`endif
            if (words_left_q == (ADDR_W + 1)'(1)) begin
              state_d = StDone;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    word_buf_d[7:0]   = byte_data;
              2'd1:    word_buf_d[15:8]  = byte_data;
              default: word_buf_d[23:16] = byte_data;
            endcase
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    byte_ready_d = (state_d == StLoad);
    busy_d       = (state_d != StIdle);
    load_done_d  = (state_d == StDone);
  end

  // Loader state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      words_left_q <= '0;
      byte_cnt_q   <= 2'd0;
      word_buf_q   <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
`ifdef INSTR_WR_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      word_buf_q   <= word_buf_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
`ifdef INSTR_WR_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  // Storage: write port from the loader, registered read port (old data on collision).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_instruction_ram_wr.sv
// Randomized scoreboard bench for instruction_ram_wr.
module tb_instruction_ram_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [7:0]  load_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        busy;
  logic        load_done;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;
`ifdef INSTR_WR_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instruction_ram_wr #(
    .ADDR_W(8),
    .DATA_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .load_addr (load_addr),
    .load_len  (load_len),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .busy      (busy),
    .load_done (load_done),
    .rd_addr   (rd_addr),
`ifdef INSTR_WR_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory image, validity, expected events.
  logic [31:0] mem_m [256];
  bit          known [256];
  int          done_q[$];
  logic [31:0] ck_q[$];
  logic [31:0] ck_m;

  typedef struct {
    int          due;
    logic [7:0]  addr;
    logic [31:0] data;
  } rd_t;
  rd_t rd_q[$];

  // Session model.
  int          s_ptr;
  int          s_left;
  int          s_nb;
  logic [31:0] s_word;
  bit          stall_en = 1'b1;

  int          rd_mode = 0;
  logic [7:0]  rd_fix = '0;
  int          sweep = 0;

  // Read-side stimulus and expectation: the word present at the read edge is due next cycle.
  always @(posedge clk) begin
    if (known[rd_addr]) rd_q.push_back('{cyc + 1, rd_addr, mem_m[rd_addr]});
    #1;
    case (rd_mode)
      0:       rd_addr = 8'($urandom);
      1:       rd_addr = rd_fix;
      default: begin
        rd_addr = 8'(sweep);
        sweep++;
      end
    endcase
  end

  // Monitor: compares read data and load_done pulses against the scoreboard queues.
  always @(negedge clk) begin : mon
    rd_t e;
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      e = rd_q.pop_front();
      if (e.due == cyc) chk($sformatf("rd_data[%02h]", e.addr), rd_data, e.data);
      else chk("rd_sample_missed", 32'(cyc), 32'(e.due));
    end
    if (load_done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("load_done_unexpected", 32'd1, 32'd0);
      end else begin
        chk("load_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
`ifdef INSTR_WR_CHECKSUM_EN
        chk("checksum", checksum, ck_q.pop_front());
`endif
      end
    end else if (done_q.size() > 0 && done_q[0] < cyc) begin
      chk("load_done_missing", 32'(cyc), 32'(done_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] l);
    load_start = 1'b1;
    load_addr  = a;
    load_len   = l;
    tick();
    load_start = 1'b0;
    load_addr  = 8'($urandom);
    load_len   = 8'($urandom);
    s_ptr  = a;
    s_left = (l == 0) ? 256 : l;
    s_nb   = 0;
    s_word = '0;
    ck_m   = '0;
  endtask

  // Offer one byte (after an optional random gap) and update the model once accepted.
  task automatic send(input logic [7:0] b);
    bit acc;
    int guard;
    if (stall_en) repeat ($urandom_range(0, 2)) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    acc   = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = byte_ready;
      tick();
      guard++;
      if (!acc && guard > 50) begin
        chk("byte_accept_timeout", 32'd0, 32'd1);
        finish_run();
      end
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    s_word[8*s_nb +: 8] = b;
    s_nb++;
    if (s_nb == 4) begin
      mem_m[s_ptr] = s_word;
      known[s_ptr] = 1'b1;
      ck_m   = ck_m ^ s_word;
      s_ptr  = (s_ptr + 1) % 256;
      s_left--;
      s_nb   = 0;
      s_word = '0;
      if (s_left == 0) begin
        done_q.push_back(cyc);
        ck_q.push_back(ck_m);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  // After the final byte the DUT sits in DONE for one cycle, then must be idle.
  task automatic end_session(input string name);
    tick();
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic session(input logic [7:0] a, input logic [7:0] l, input string name);
    int n;
    n = (l == 0) ? 256 : l;
    start(a, l);
    for (int i = 0; i < n; i++) send_word($urandom);
    end_session(name);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    chk("reset_byte_ready", 32'(byte_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_load_done", 32'(load_done), 32'd0);
    rst = 1'b0;
    tick();

    // Bytes offered while idle must be ignored.
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_data = 8'($urandom);
      @(negedge clk);
      chk("idle_byte_ready", 32'(byte_ready), 32'd0);
      tick();
    end
    byte_valid = 1'b0;

    // Two-word directed load.
    start(8'h10, 8'd2);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_byte_ready", 32'(byte_ready), 32'd1);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    end_session("basic");

    // Address wrap at the top of memory.
    session(8'hFF, 8'd2, "wrap");

    // Collision: read old word in the write cycle, new word one cycle later.
    rd_fix  = 8'h10;
    rd_mode = 1;
    tick();
    tick();
    start(8'h10, 8'd1);
    send_word(32'hCAFE_F00D);
    end_session("collide");
    tick();
    rd_mode = 0;

    // Restart attempt mid-session must be ignored.
    session(8'h80, 8'd1, "pre80");
    start(8'h20, 8'd2);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    load_start = 1'b1;
    load_addr  = 8'h80;
    load_len   = 8'd5;
    tick();
    load_start = 1'b0;
    send(8'h44);
    send_word(32'h0BAD_F00D);
    end_session("restart");

    // Reset after six bytes: first word kept, second address untouched, no done.
    session(8'h31, 8'd1, "pre31");
    start(8'h30, 8'd2);
    send_word(32'hA5A5_5A5A);
    send(8'h01);
    send(8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_byte_ready", 32'(byte_ready), 32'd0);
    chk("abort_load_done", 32'(load_done), 32'd0);
    tick();
    tick();

    // Complementary halves; XOR over the session is all ones.
    start(8'h50, 8'd2);
    send_word(32'h0000_FFFF);
    send_word(32'hFFFF_0000);
    end_session("cksum");

    // Randomized sessions.
    for (int k = 0; k < 10; k++) begin
      session(8'($urandom), 8'($urandom_range(1, 5)), "rand");
    end

    // Full-depth session (length 0).
    stall_en = 1'b0;
    session(8'h40, 8'd0, "full");
    stall_en = 1'b1;
    session(8'($urandom), 8'd3, "post_full");

    // Sweep every address through the read port.
    sweep   = 0;
    rd_mode = 2;
    repeat (260) tick();
    rd_mode = 0;
    tick();
    tick();
    chk("done_events_left", 32'(done_q.size()), 32'd0);
    finish_run();
  end

  // Absolute time bound.
  initial begin
    #2000000;
    chk("global_timeout", 32'd0, 32'd1);
    finish_run();
  end

endmodule

// File: doc/instruction_ram_wr.md
INSTRUCTION_RAM_WR -- requirements
Module: instruction_ram_wr

Interface
REQ-001 Parameter ADDR_W, default 8: word address width; memory depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 32: instruction word width; fixed at 4 bytes.
REQ-003 clk  input  1: single clock; all logic on posedge clk.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 load_start  input  1: single-cycle pulse that begins a load session.
REQ-006 load_addr  input  ADDR_W: first word address, sampled on load_start.
REQ-007 load_len  input  ADDR_W: word count, sampled on load_start; 0 means 2^ADDR_W words.
REQ-008 byte_valid  input  1: byte stream valid.
REQ-009 byte_data  input  8: byte stream data.
REQ-010 byte_ready  output  1: byte accepted when byte_valid and byte_ready are both high.
REQ-011 busy  output  1: high while a load session is active.
REQ-012 load_done  output  1: one-cycle pulse after the final word is written.
REQ-013 rd_addr  input  ADDR_W: sequencer read address.
REQ-014 rd_data  output  DATA_W: registered read data.

Function
REQ-015 Storage: 2^ADDR_W x DATA_W array; one write port driven by the loader, one synchronous read port.
REQ-016 Read: rd_data <= mem[rd_addr] every cycle; latency is 1 clock.
REQ-017 Read and write to the same address in the same cycle: rd_data returns the old word (read-before-write).
REQ-018 FSM states IDLE, LOAD, DONE.
REQ-019 IDLE -> LOAD on load_start: capture wr_ptr=load_addr and words_left=load_len (0 -> 2^ADDR_W); clear byte_cnt.
REQ-020 LOAD: byte_ready=1; in every other state byte_ready=0.
REQ-021 Byte packing is little-endian: byte 0 -> [7:0], byte 1 -> [15:8], byte 2 -> [23:16], byte 3 -> [31:24].
REQ-022 On acceptance of byte 3, mem[wr_ptr] is written with the assembled word at the same clock edge. Then wr_ptr+1, words_left-1, and byte_cnt returns to 0.
REQ-023 wr_ptr wraps from 2^ADDR_W-1 to 0 without error.
REQ-024 LOAD -> DONE on the edge that writes the last word; DONE -> IDLE after exactly 1 cycle.
REQ-025 load_done=1 only in DONE; busy=1 in LOAD and DONE.
REQ-026 load_start while busy is ignored; the session is not restarted and no pointers change.
REQ-027 byte_valid low mid-word stalls packing; partial bytes are held indefinitely.
REQ-028 Bytes presented in IDLE/DONE are not accepted and not stored.

Reset
REQ-029 rst forces state IDLE, byte_ready=0, busy=0, load_done=0, byte_cnt=0, words_left=0, wr_ptr=0.
REQ-030 rst does not clear the memory array; rd_data is not reset.
REQ-031 rst during LOAD aborts the session; words already written remain; the partial word is discarded; no load_done is issued.

Configuration
REQ-032 Macro INSTR_WR_CHECKSUM_EN: when defined, add output checksum [DATA_W-1:0].
REQ-033 With the macro defined: checksum clears on rst and on load_start accepted in IDLE, XORs each written word, and is stable from DONE until the next session.
REQ-034 Without the macro: no checksum port and no checksum logic.

Verification
REQ-035 load_start, addr=0x10, len=2; bytes 78 56 34 12 EF BE AD DE -> mem[0x10]=0x12345678, mem[0x11]=0xDEADBEEF; load_done pulses 1 cycle after byte 8.
REQ-036 addr=0xFF, len=2; words A, B -> mem[0xFF]=A, mem[0x00]=B (wrap).
REQ-037 rd_addr=0x10 held while writing 0xCAFEF00D there -> rd_data shows the old word in the write cycle and 0xCAFEF00D one cycle later.
REQ-038 load_start re-pulsed mid-session with addr=0x80 -> ignored; writes continue at the original pointer.
REQ-039 rst after 6 of 8 bytes, len=2 -> first word retained; second word address unchanged; no load_done; busy=0 next cycle.
REQ-040 With INSTR_WR_CHECKSUM_EN defined, words 0x0000FFFF and 0xFFFF0000 -> checksum=0xFFFFFFFF at DONE.
